// File: rtl/vis_scoreboard_issue_pkg.sv
// Shared types and sizing for the vector issue stage and its scoreboard.
package vis_scoreboard_issue_pkg;

    localparam int VECTOR_REGISTERS = 32;
    localparam int VECTOR_LANES     = 8;
    localparam int DATA_WIDTH       = 32;
    localparam int MAX_VL           = 64;
    localparam int MAX_LMUL         = 8;

    localparam int VREG_W = $clog2(VECTOR_REGISTERS);
    localparam int VL_W   = $clog2(MAX_VL) + 1;
    localparam int LANE_W = $clog2(VECTOR_LANES);
    localparam int CNT_W  = (MAX_LMUL > 1) ? $clog2(MAX_LMUL) : 1;

    // RVV funct3 operand categories
    localparam logic [2:0] OPIVV = 3'b000;
    localparam logic [2:0] OPFVV = 3'b001;
    localparam logic [2:0] OPMVV = 3'b010;
    localparam logic [2:0] OPIVI = 3'b011;

    typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} vis_state_e;

    typedef logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] lane_data_t;

    typedef struct packed {
        logic [VREG_W-1:0]     src1;
        logic [VREG_W-1:0]     src2;
        logic [VREG_W-1:0]     dst;
        logic [VL_W-1:0]       vl;
        logic [VL_W-1:0]       maxvl;
        logic [5:0]            funct6;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] data1;
        logic [4:0]            imm;
        logic                  lock;
        logic                  reconfigure;
        logic                  dst_iszero;
    } remapped_v_instr;

    typedef struct packed {
        logic [VREG_W-1:0]       dst;
        logic [VREG_W-1:0]       src1;
        logic [VREG_W-1:0]       src2;
        logic [5:0]              funct6;
        logic [2:0]              funct3;
        logic [VL_W-1:0]         vl;         // elements remaining from this uop on
        logic                    head;
        logic                    last;
        logic [VECTOR_LANES-1:0] lane_valid;
        logic [VECTOR_LANES-1:0] mask;
        lane_data_t              data1;
        lane_data_t              data2;
    } vis_uop_t;

    // Integer reductions (vredsum..vredmax) live in OPMVV funct6 000xxx
    function automatic logic is_reduction(input logic [5:0] f6, input logic [2:0] f3);
        return (f3 == OPMVV) && (f6[5:3] == 3'b000);
    endfunction

    // src1 names a vector register (as opposed to an immediate or scalar)
    function automatic logic uses_vsrc1(input logic [2:0] f3);
        return (f3 == OPIVV) || (f3 == OPFVV) || (f3 == OPMVV);
    endfunction

endpackage

// File: rtl/vis_scoreboard_issue_scoreboard.sv
// One lane's slice of the scoreboard: a pending and a locked bit per vreg.
module vis_scoreboard
    import vis_scoreboard_issue_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clear_i,
    input  logic              set_en_i,
    input  logic [VREG_W-1:0] set_addr_i,
    input  logic              set_pend_i,
    input  logic              set_lock_i,
    input  logic              wb_en_i,
    input  logic [VREG_W-1:0] wb_addr_i,
    input  logic              unlock_en_i,
    input  logic [VREG_W-1:0] unlock_addr_i,
    input  logic [VREG_W-1:0] q_src1_i,
    input  logic [VREG_W-1:0] q_src2_i,
    input  logic [VREG_W-1:0] q_dst_i,
    output logic              hz_src1_o,
    output logic              hz_src2_o,
    output logic              hz_dst_o,
    output logic              busy_o
);
    localparam int R = VECTOR_REGISTERS;

    logic [R-1:0] pending, locked;
    logic [R-1:0] set_dec, wb_dec, unl_dec;

    assign set_dec = set_en_i    ? (R'(1) << set_addr_i)    : '0;
    assign wb_dec  = wb_en_i     ? (R'(1) << wb_addr_i)     : '0;
    assign unl_dec = unlock_en_i ? (R'(1) << unlock_addr_i) : '0;

    // Clear first, then OR in the sets so a same-cycle set wins
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending <= '0;
            locked  <= '0;
        end else if (clear_i) begin
            pending <= '0;
            locked  <= '0;
        end else begin
            pending <= (pending & ~wb_dec)  | (set_pend_i ? set_dec : '0);
            locked  <= (locked  & ~unl_dec) | (set_lock_i ? set_dec : '0);
        end
    end

    assign hz_src1_o = pending[q_src1_i];
    assign hz_src2_o = pending[q_src2_i];
    assign hz_dst_o  = locked[q_dst_i];
    assign busy_o    = |pending | |locked;

endmodule

// File: rtl/vis_scoreboard_issue.sv
// Vector issue stage: expands one instr into lane-wide uops, stalls on
// scoreboard hazards and presents each uop through a registered valid/ready port.
module vis_scoreboard_issue
    import vis_scoreboard_issue_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    valid_i,
    input  remapped_v_instr         instr_i,
    output logic                    ready_o,
    output logic [VREG_W-1:0]       rd_addr_1_o,
    output logic [VREG_W-1:0]       rd_addr_2_o,
    input  lane_data_t              rd_data_1_i,
    input  lane_data_t              rd_data_2_i,
    output logic                    valid_o,
    output vis_uop_t                uop_o,
    input  logic                    ready_i,
    input  logic [VECTOR_LANES-1:0] wb_en_i,
    input  logic [VREG_W-1:0]       wb_addr_i,
    input  logic                    unlock_en_i,
    input  logic [VREG_W-1:0]       unlock_addr_i,
    output logic                    idle_o,
    output logic                    drained_o
);
    localparam int L = VECTOR_LANES;

    vis_state_e        state_q, state_d;
    logic [CNT_W-1:0]  exp_cnt_q, exp_cnt_d;

    logic              red, src1_vec, expanding, hazard, issue, last_uop, sb_clear;
    logic [VREG_W-1:0] uop_dst, uop_src1, uop_src2;
    logic [VL_W-1:0]   elem_base, rem, maxvl_uops, uop_lim;
    logic [L-1:0]      lane_mask, set_lane, hz1, hz2, hzd, busy;
    logic [DATA_WIDTH-1:0] imm_sext;
    vis_uop_t          uop_next;

    assign red      = is_reduction(instr_i.funct6, instr_i.funct3);
    assign src1_vec = uses_vsrc1(instr_i.funct3);

    // Reductions accumulate into a fixed dst from a fixed scalar-in-vreg src1
    assign uop_src2 = instr_i.src2 + VREG_W'(exp_cnt_q);
    assign uop_src1 = red ? instr_i.src1 : instr_i.src1 + VREG_W'(exp_cnt_q);
    assign uop_dst  = red ? instr_i.dst  : instr_i.dst  + VREG_W'(exp_cnt_q);

    assign rd_addr_1_o = uop_src1;
    assign rd_addr_2_o = uop_src2;

    assign elem_base = VL_W'(exp_cnt_q) << LANE_W;
    assign rem       = instr_i.vl - elem_base;

    for (genvar l = 0; l < L; l++) begin : g_mask
        assign lane_mask[l] = rem > VL_W'(l);
    end

    // A maxvl smaller than one uop still yields a single uop
    assign maxvl_uops = instr_i.maxvl >> LANE_W;
    assign uop_lim    = (maxvl_uops == '0)              ? VL_W'(1)        :
                        (maxvl_uops > VL_W'(MAX_LMUL)) ? VL_W'(MAX_LMUL) : maxvl_uops;
    assign last_uop   = ((elem_base + VL_W'(L)) >= instr_i.vl) ||
                        (VL_W'(exp_cnt_q) == uop_lim - VL_W'(1));

    assign hazard = |(lane_mask & ((hz1 & {L{src1_vec}}) | hz2 | hzd));

    // IDLE issues the first uop directly so an unstalled instr costs one cycle
    assign expanding = (state_q == EXPAND) ||
                       ((state_q == IDLE) && valid_i && !instr_i.reconfigure && (instr_i.vl != '0));
    assign issue     = expanding && !hazard && (!valid_o || ready_i);

    assign drained_o = !(|busy) && !valid_o;
    assign idle_o    = drained_o && !valid_i;

    // State and expansion counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            exp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    // Next state: leave EXPAND only when the last uop actually issues
    always_comb begin
        state_d   = state_q;
        exp_cnt_d = exp_cnt_q;
        if (issue) exp_cnt_d = last_uop ? '0 : exp_cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (valid_i && instr_i.reconfigure) state_d = DRAIN;
                else if (expanding && !(issue && last_uop)) state_d = EXPAND;
            end
            EXPAND:  if (issue && last_uop) state_d = IDLE;
            DRAIN:   if (drained_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: instr handshake and scoreboard flush after a drain
    always_comb begin
        ready_o  = 1'b0;
        sb_clear = 1'b0;
        case (state_q)
            IDLE:    ready_o = valid_i && !instr_i.reconfigure &&
                               ((instr_i.vl == '0) || (issue && last_uop));
            EXPAND:  ready_o = issue && last_uop;
            DRAIN: begin
                ready_o  = drained_o;
                sb_clear = drained_o;
            end
            default: ready_o = 1'b0;
        endcase
    end

    assign imm_sext = {{(DATA_WIDTH-5){instr_i.imm[4]}}, instr_i.imm};

    // Assemble the uop; src1 operand source depends on the instr category
    always_comb begin
        uop_next            = '0;
        uop_next.dst        = uop_dst;
        uop_next.src1       = uop_src1;
        uop_next.src2       = uop_src2;
        uop_next.funct6     = instr_i.funct6;
        uop_next.funct3     = instr_i.funct3;
        uop_next.vl         = rem;
        uop_next.head       = (exp_cnt_q == '0);
        uop_next.last       = last_uop;
        uop_next.lane_valid = lane_mask;
        uop_next.mask       = red ? {{(L-1){1'b0}}, last_uop} : lane_mask;
        uop_next.data2      = rd_data_2_i;
        for (int l = 0; l < L; l++) begin
            if (red)                          uop_next.data1[l] = (l == 0) ? rd_data_1_i[0] : '0;
            else if (instr_i.funct3 == OPIVI) uop_next.data1[l] = imm_sext;
            else if (src1_vec)                uop_next.data1[l] = rd_data_1_i[l];
            else                              uop_next.data1[l] = instr_i.data1;
        end
    end

    // Output register: load on issue, hold while the consumer stalls
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            uop_o   <= '0;
        end else if (issue) begin
            valid_o <= 1'b1;
            uop_o   <= uop_next;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    assign set_lane = issue ? lane_mask : '0;

    for (genvar l = 0; l < L; l++) begin : g_lane
        vis_scoreboard u_sb (
            .clk_i         (clk_i),
            .rstn_i        (rstn_i),
            .clear_i       (sb_clear),
            .set_en_i      (set_lane[l]),
            .set_addr_i    (uop_dst),
            .set_pend_i    (!instr_i.dst_iszero),
            .set_lock_i    (instr_i.lock),
            .wb_en_i       (wb_en_i[l]),
            .wb_addr_i     (wb_addr_i),
            .unlock_en_i   (unlock_en_i),
            .unlock_addr_i (unlock_addr_i),
            .q_src1_i      (uop_src1),
            .q_src2_i      (uop_src2),
            .q_dst_i       (uop_dst),
            .hz_src1_o     (hz1[l]),
            .hz_src2_o     (hz2[l]),
            .hz_dst_o      (hzd[l]),
            .busy_o        (busy[l])
        );
    end

endmodule

// File: tb/tb_vis_scoreboard_issue.sv
// Directed bench for the vector issue stage with a uop scoreboard queue.
module tb_vis_scoreboard_issue;
    import vis_scoreboard_issue_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rstn_i;
    logic                    valid_i;
    remapped_v_instr         instr_i;
    logic                    ready_o;
    logic [VREG_W-1:0]       rd_addr_1_o, rd_addr_2_o;
    lane_data_t              rd_data_1_i, rd_data_2_i;
    logic                    valid_o;
    vis_uop_t                uop_o;
    logic                    ready_i;
    logic [VECTOR_LANES-1:0] wb_en_i;
    logic [VREG_W-1:0]       wb_addr_i;
    logic                    unlock_en_i;
    logic [VREG_W-1:0]       unlock_addr_i;
    logic                    idle_o, drained_o;

    int       checks = 0;
    int       failures = 0;
    vis_uop_t q[$];
    logic     last_rdy, s_valid, s_drained, s_idle;

    always #5 clk_i = ~clk_i;

    vis_scoreboard_issue dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .instr_i(instr_i),
        .ready_o(ready_o), .rd_addr_1_o(rd_addr_1_o), .rd_addr_2_o(rd_addr_2_o),
        .rd_data_1_i(rd_data_1_i), .rd_data_2_i(rd_data_2_i), .valid_o(valid_o),
        .uop_o(uop_o), .ready_i(ready_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
        .unlock_en_i(unlock_en_i), .unlock_addr_i(unlock_addr_i),
        .idle_o(idle_o), .drained_o(drained_o)
    );

    // VRF model: each element encodes its register and lane
    function automatic logic [31:0] vrf(input logic [4:0] a, input int l);
        return 32'hA500_0000 | (32'(a) << 8) | 32'(l);
    endfunction

    for (genvar l = 0; l < VECTOR_LANES; l++) begin : g_vrf
        assign rd_data_1_i[l] = vrf(rd_addr_1_o, l);
        assign rd_data_2_i[l] = vrf(rd_addr_2_o, l);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic remapped_v_instr mk(input int dst, input int s1, input int s2,
                                           input int vl, input int maxvl, input logic [2:0] f3);
        remapped_v_instr r;
        r = '0;
        r.dst = 5'(dst); r.src1 = 5'(s1); r.src2 = 5'(s2);
        r.vl = 7'(vl); r.maxvl = 7'(maxvl); r.funct3 = f3;
        return r;
    endfunction

    // Expected uop sequence for one instr, straight from the behavioural rules
    task automatic push_instr(input remapped_v_instr in);
        vis_uop_t u;
        int rem, lim;
        bit red, is_last;
        red = (in.funct3 == 3'b010) && (in.funct6[5:3] == 3'b000);
        lim = int'(in.maxvl) / 8;
        if (lim > 8) lim = 8;
        if (lim == 0) lim = 1;
        for (int k = 0; k < 8; k++) begin
            rem = int'(in.vl) - k * 8;
            is_last = ((k + 1) * 8 >= int'(in.vl)) || (k == lim - 1);
            u = '0;
            u.dst  = red ? in.dst  : 5'(in.dst + 5'(k));
            u.src1 = red ? in.src1 : 5'(in.src1 + 5'(k));
            u.src2 = 5'(in.src2 + 5'(k));
            u.funct6 = in.funct6; u.funct3 = in.funct3;
            u.vl = 7'(rem); u.head = (k == 0); u.last = is_last;
            for (int l = 0; l < 8; l++) begin
                u.lane_valid[l] = (rem > l);
                u.data2[l] = vrf(u.src2, l);
                case (in.funct3)
                    3'b011:                 u.data1[l] = {{27{in.imm[4]}}, in.imm};
                    3'b100, 3'b101, 3'b110: u.data1[l] = in.data1;
                    default:                u.data1[l] = red ? ((l == 0) ? vrf(in.src1, 0) : 32'h0)
                                                             : vrf(u.src1, l);
                endcase
            end
            u.mask = red ? {7'b0, is_last} : u.lane_valid;
            q.push_back(u);
            if (is_last) break;
        end
    endtask

    // One cycle: settle, sample, check the presented uop, advance to next negedge
    task automatic tick();
        #1;
        last_rdy = ready_o; s_valid = valid_o; s_drained = drained_o; s_idle = idle_o;
        if (valid_o) begin
            chk("uop_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                checks++;
                assert (uop_o === q[0]) else begin
                    failures++;
                    $error("FAIL uop observed=%h expected=%h", uop_o, q[0]);
                end
                if (ready_i) void'(q.pop_front());
            end
        end
        @(negedge clk_i);
    endtask

    task automatic run_instr(input remapped_v_instr in, output int n);
        bit got;
        push_instr(in);
        instr_i = in; valid_i = 1'b1; n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick(); n++; got = last_rdy;
        end
        valid_i = 1'b0;
        chk("instr_handshake", 32'(got), 1);
    endtask

    task automatic flush();
        for (int i = 0; i < 40 && (q.size() != 0 || valid_o); i++) tick();
        chk("queue_empty", 32'(q.size()), 0);
    endtask

    task automatic wb_all();
        for (int r = 0; r < 32; r++) begin
            wb_en_i = '1; wb_addr_i = 5'(r); unlock_en_i = 1'b1; unlock_addr_i = 5'(r);
            tick();
        end
        wb_en_i = '0; unlock_en_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        remapped_v_instr in;
        int n;
        bit got;
        rstn_i = 1'b0; valid_i = 1'b0; instr_i = '0; ready_i = 1'b1;
        wb_en_i = '0; wb_addr_i = '0; unlock_en_i = 1'b0; unlock_addr_i = '0;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        #1;
        chk("reset_valid_o", 32'(valid_o), 0);
        chk("reset_ready_o", 32'(ready_o), 0);
        chk("reset_idle_o", 32'(idle_o), 1);
        chk("reset_drained_o", 32'(drained_o), 1);
        chk("reset_uop_o_dst", 32'(uop_o.dst), 0);
        @(negedge clk_i);

        // vl=20 over 8 lanes: three uops, ready_o only with the third
        run_instr(mk(4, 10, 20, 20, 64, 3'b000), n);
        chk("vl20_ready_cycle", 32'(n), 3);
        flush();
        wb_all();

        // RAW: second instr reads v2 while first instr's write is pending
        run_instr(mk(2, 0, 1, 8, 64, 3'b000), n);
        chk("raw_first_ready_cycle", 32'(n), 1);
        in = mk(3, 0, 2, 8, 64, 3'b000);
        push_instr(in); instr_i = in; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("raw_stall", 32'(last_rdy), 0);
        end
        wb_en_i = '1; wb_addr_i = 5'd2;
        tick(); chk("raw_stall_wb_cycle", 32'(last_rdy), 0);
        wb_en_i = '0;
        tick(); chk("raw_issue_after_wb", 32'(last_rdy), 1);
        valid_i = 1'b0;
        flush();
        wb_all();

        // Backpressure mid-expansion with a scalar operand
        in = mk(12, 0, 16, 32, 64, 3'b100); in.data1 = 32'hDEADBEEF;
        push_instr(in); instr_i = in; valid_i = 1'b1;
        tick(); tick();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", 32'(s_valid), 1);
            chk("bp_no_ready", 32'(last_rdy), 0);
        end
        chk("bp_queue_depth", 32'(q.size()), 3);
        ready_i = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(); got = last_rdy;
        end
        chk("bp_instr_done", 32'(got), 1);
        valid_i = 1'b0;
        flush();
        wb_all();

        // Reconfigure waits for pending and locked v7 to clear
        in = mk(7, 0, 0, 8, 64, 3'b000); in.lock = 1'b1;
        run_instr(in, n);
        flush();
        in = '0; in.reconfigure = 1'b1; in.vl = 7'd8;
        instr_i = in; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("drain_wait", 32'(last_rdy), 0);
        end
        chk("drain_not_drained", 32'(s_drained), 0);
        wb_en_i = '1; wb_addr_i = 5'd7;
        tick(); chk("drain_wb_cycle", 32'(last_rdy), 0);
        wb_en_i = '0;
        tick(); chk("drain_still_locked", 32'(last_rdy), 0);
        unlock_en_i = 1'b1; unlock_addr_i = 5'd7;
        tick(); chk("drain_unlock_cycle", 32'(last_rdy), 0);
        unlock_en_i = 1'b0;
        tick(); chk("drain_done_ready", 32'(last_rdy), 1);
        valid_i = 1'b0;
        tick();
        chk("drain_drained_after", 32'(s_drained), 1);
        chk("drain_idle_after", 32'(s_idle), 1);

        // vl=0 consumed at once, no uop
        instr_i = mk(5, 0, 0, 0, 64, 3'b000); valid_i = 1'b1;
        tick(); chk("vl0_ready", 32'(last_rdy), 1);
        valid_i = 1'b0;
        tick(); chk("vl0_no_valid", 32'(s_valid), 0);

        // Same-cycle writeback and issue on v9 lane 0: set wins
        run_instr(mk(9, 0, 0, 1, 64, 3'b000), n);
        in = mk(9, 0, 0, 1, 64, 3'b000);
        push_instr(in); instr_i = in; valid_i = 1'b1;
        wb_en_i = 8'h01; wb_addr_i = 5'd9;
        tick(); chk("setwin_issue", 32'(last_rdy), 1);
        wb_en_i = '0; valid_i = 1'b0;
        flush();
        tick(); chk("setwin_pending_kept", 32'(s_drained), 0);
        wb_en_i = 8'h01; wb_addr_i = 5'd9;
        tick();
        wb_en_i = '0;
        tick(); chk("setwin_cleared", 32'(s_drained), 1);

        // Reduction: fixed dst/src1, mask only on lane 0 of last uop
        in = mk(20, 21, 24, 16, 64, 3'b010);
        run_instr(in, n);
        chk("red_uops", 32'(n), 2);
        flush();
        // Immediate operand, negative
        in = mk(26, 0, 27, 8, 8, 3'b011); in.imm = 5'b10110;
        run_instr(in, n);
        chk("imm_uops", 32'(n), 1);
        flush();
        // maxvl bounds the expansion below vl
        run_instr(mk(28, 0, 4, 64, 16, 3'b000), n);
        chk("maxvl_uops", 32'(n), 2);
        flush();
        wb_all();
        tick(); chk("final_drained", 32'(s_drained), 1);

        // Reset mid-expansion drops everything
        instr_i = mk(10, 0, 11, 32, 64, 3'b000); valid_i = 1'b1;
        push_instr(instr_i);
        tick();
        rstn_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("midreset_valid", 32'(valid_o), 0);
        chk("midreset_ready", 32'(ready_o), 0);
        q.delete();
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick(); chk("midreset_drained", 32'(s_drained), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
